baby_kyber_decrypt: RTL
=======================

# baby_kyber_decrypt

Sequential decryption engine for the Baby Kyber toy scheme (q = 17, n = 4 coefficients, k = 2, ring Z_17[x]/(x^4+1)). It recovers the 4-bit message from a ciphertext (u, v) using the secret polynomial vector s, computing m = Decode(v − sᵀ·u). It sits downstream of the encryption block and consumes its ciphertext layout unchanged. The engine uses one modular multiply-accumulate per cycle under a start/done handshake.

## Interface
- No parameters; q = 17, n = 4 and k = 2 are fixed.
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- decryption_enable  input  1  start request, sampled only in IDLE.
- ciphertext  input  signed 32 × [1:0][1:0][3:0]  [0][k][i] = u[k] coefficient i; [1][0][i] = v coefficient i; [1][1][*] ignored.
- secret_key  input  signed 32 × [1:0][3:0]  s[k] coefficient i.
- message  output  32  recovered message in bits [3:0]; bits [31:4] always 0.
- busy  output  1  high from the cycle after start acceptance through the DONE cycle.
- decryption_done  output  1  one-cycle pulse when message updates.

## Operation
- FSM states: IDLE → LOAD → MAC → REDUCE → DECODE → DONE → IDLE.
- IDLE: if decryption_enable = 1, go to LOAD; otherwise stay.
- LOAD (1 cycle): register all u, v and s operands reduced to [0,16] using true modulo, so negative inputs wrap (−1 → 16, −8 → 9). Clear the four w accumulators and the counters.
- MAC (32 cycles): counters k (0..1), i (0..3), j (0..3), with j innermost, then i, then k.
  - Per cycle, compute p = s[k][j]·u[k][(i−j) mod 4]. The 9-bit product fits 16·16.
  - If j ≤ i, w[i] ← (w[i] + p) mod 17; if j > i, w[i] ← (w[i] − p) mod 17 (negacyclic wrap). w stays in [0,16] every cycle.
- REDUCE (1 cycle): d[i] ← (v[i] − w[i]) mod 17, range [0,16].
- DECODE (1 cycle): bit_i = 1 iff 5 ≤ d[i] ≤ 12, else 0. The tie d = 13 decodes to 0. Register message[3−i] ← bit_i, so v coefficient i carries message bit 3−i, matching the encoder's ordering.
- DONE (1 cycle): decryption_done = 1, then return to IDLE.
- message holds its value until the next DECODE or reset.
- decryption_enable while busy is ignored; it is not queued.
- Inputs are sampled only in LOAD. Changes after LOAD do not affect the result in progress.

## Timing
- Reset values: message = 0, busy = 0, decryption_done = 0, state = IDLE, accumulators = 0.
- Start sampled high at edge T0 (in IDLE):
  - LOAD in cycle T0..T0+1.
  - MAC in edges T0+1..T0+32.
  - REDUCE at T0+33.
  - DECODE at T0+34; message becomes valid after edge T0+35.
  - decryption_done is high for exactly one cycle after edge T0+35.
- busy is high after edges T0+1..T0+35 and low after T0+36. Total latency start → done is 35 edges.
- If decryption_enable stays high continuously, back-to-back operations start every 37 cycles (DONE → IDLE → LOAD).
- rst_n low at any point, including mid-MAC: all outputs clear immediately (asynchronously), the FSM returns to IDLE, and no done pulse is produced for the aborted operation.

## Configuration
- BABY_KYBER_DECRYPT_NOISE_OUT_EN, defined:
  - Adds output port noise_out, unsigned 5 × [3:0].
  - noise_out is registered with message in DECODE and equals d[i].
  - Resets to 0 and holds between operations.
- Undefined: the port and its registers are absent; all other behaviour is identical.

## Test plan
- Zero-key decode: s = 0, u arbitrary, v = [9,0,9,0], pulse start. Required: done pulses after 35 edges; message = 0x0000000A; busy high 35 cycles.
- Negacyclic wrap: s[0] = [0,1,0,0], s[1] = 0, u[0] = [0,0,0,1], v = [8,0,0,0]. Required: w = [16,0,0,0], d0 = 9, message = 0x8.
- Signed input reduction: s = 0, v = [−8, −17, 26, −34]. Required: reduced v = [9,0,9,0], message = 0xA. With the macro: noise_out = [9,0,9,0].
- Decision boundaries: s = 0, v = [4,5,12,13]. Required: message = 0x6. Confirms 5 and 12 decode to 1, and 4 and 13 decode to 0.
- Busy/abort: pulse start, pulse start again at T0+10 (ignored; done still at T0+35). Then start a new operation and drop rst_n at its MAC cycle 10. Required: message = 0 and busy = 0 immediately, no done pulse; a fresh start after reset gives the correct result.
- Round-trip: feed encryption-block ciphertexts for all 16 message values with zero noise. Required: recovered message equals the original each time.

Source files
------------

// File: rtl/baby_kyber_decrypt.sv
// baby_kyber_decrypt
//   Sequential Baby Kyber decryption (q = 17, n = 4, k = 2, ring Z_17[x]/(x^4+1)).
//   Computes m = Decode(v - s^T * u) with one modular multiply-accumulate per cycle.
//   Sequence: IDLE -> LOAD -> MAC (32 cycles) -> REDUCE -> DECODE -> DONE -> IDLE.
//
// Ports
//   clk               rising-edge clock
//   rst_n             asynchronous active-low reset
//   decryption_enable start request, honoured only in IDLE
//   ciphertext        [0][k][i] = u[k] coeff i, [1][0][i] = v coeff i, [1][1][*] ignored
//   secret_key        [k][i] = s[k] coeff i
//   message           recovered message in [3:0], upper bits zero
//   busy              high from MAC through DONE
//   decryption_done   one-cycle pulse in DONE
//   noise_out         per-coefficient d[i] = (v - s^T u)[i], only with the macro below
//
// Configuration
//   BABY_KYBER_DECRYPT_NOISE_OUT_EN : adds the registered noise_out port.

module baby_kyber_decrypt (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              decryption_enable,
   input  logic signed [1:0][1:0][3:0][31:0] ciphertext,
   input  logic signed [1:0][3:0][31:0]      secret_key,
   output logic [31:0]                       message,
   output logic                              busy,
   output logic                              decryption_done
`ifdef BABY_KYBER_DECRYPT_NOISE_OUT_EN
   ,
   output logic [3:0][4:0]                   noise_out
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_MAC,
      S_REDUCE,
      S_DECODE,
      S_DONE
   } state_t;

   state_t state_q, state_n;

   logic [1:0][3:0][4:0] u_q;
   logic [1:0][3:0][4:0] s_q;
   logic [3:0][4:0]      v_q;
   logic [3:0][4:0]      w_q;
   logic [3:0][4:0]      d_q;
   logic [3:0][4:0]      d_next;
   logic [3:0]           msg_q;
   logic                 k_q;
   logic [1:0]           i_q;
   logic [1:0]           j_q;

   logic                 mac_last;
   logic [1:0]           u_idx;
   logic [4:0]           s_sel;
   logic [4:0]           u_sel;
   logic [4:0]           w_sel;
   logic [9:0]           prod;
   logic [4:0]           prod_r;
   logic [5:0]           acc_add;
   logic [5:0]           acc_sub;
   logic [5:0]           acc_new;
   logic [4:0]           w_next;

   logic                 unused_ct;
   assign unused_ct = ^ciphertext[1][1];

   // True modulo: the remainder takes the dividend's sign, so fold negatives up.
   function automatic logic [4:0] mod17(input logic signed [31:0] x);
      logic signed [31:0] r;
      r = x % 32'sd17;
      if (r < 32'sd0) begin
         r = r + 32'sd17;
      end
      return 5'(r);
   endfunction

   // ---------------- FSM ----------------
   assign mac_last = k_q && (i_q == 2'd3) && (j_q == 2'd3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_n;
      end
   end

   always_comb begin
      state_n = state_q;
      case (state_q)
         S_IDLE:   if (decryption_enable) state_n = S_LOAD;
         S_LOAD:   state_n = S_MAC;
         S_MAC:    if (mac_last) state_n = S_REDUCE;
         S_REDUCE: state_n = S_DECODE;
         S_DECODE: state_n = S_DONE;
         S_DONE:   state_n = S_IDLE;
         default:  state_n = S_IDLE;
      endcase
   end

   assign busy            = (state_q == S_MAC) || (state_q == S_REDUCE) ||
                            (state_q == S_DECODE) || (state_q == S_DONE);
   assign decryption_done = (state_q == S_DONE);
   assign message         = {28'd0, msg_q};

   // ---------------- MAC datapath ----------------
   // u index (i - j) mod 4 falls out of 2-bit wraparound.
   assign u_idx  = i_q - j_q;
   assign s_sel  = s_q[k_q][j_q];
   assign u_sel  = u_q[k_q][u_idx];
   assign w_sel  = w_q[i_q];
   assign prod   = {5'd0, s_sel} * {5'd0, u_sel};
   assign prod_r = 5'(prod % 10'd17);

   // Subtraction is done as w + 17 - p so the intermediate never goes negative.
   assign acc_add = {1'b0, w_sel} + {1'b0, prod_r};
   assign acc_sub = {1'b0, w_sel} + 6'd17 - {1'b0, prod_r};

   always_comb begin
      acc_new = (j_q <= i_q) ? acc_add : acc_sub;
      if (acc_new >= 6'd17) begin
         acc_new = acc_new - 6'd17;
      end
   end
   assign w_next = 5'(acc_new);

   always_comb begin
      logic [5:0] t;
      t      = '0;
      d_next = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         t = {1'b0, v_q[i]} + 6'd17 - {1'b0, w_q[i]};
         if (t >= 6'd17) begin
            t = t - 6'd17;
         end
         d_next[i] = 5'(t);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         u_q   <= '0;
         s_q   <= '0;
         v_q   <= '0;
         w_q   <= '0;
         d_q   <= '0;
         msg_q <= '0;
         k_q   <= 1'b0;
         i_q   <= '0;
         j_q   <= '0;
      end else begin
         case (state_q)
            S_LOAD: begin
               for (int unsigned k = 0; k < 2; k++) begin
                  for (int unsigned i = 0; i < 4; i++) begin
                     u_q[k][i] <= mod17(ciphertext[0][k][i]);
                     s_q[k][i] <= mod17(secret_key[k][i]);
                  end
               end
               for (int unsigned i = 0; i < 4; i++) begin
                  v_q[i] <= mod17(ciphertext[1][0][i]);
               end
               w_q <= '0;
               k_q <= 1'b0;
               i_q <= '0;
               j_q <= '0;
            end
            S_MAC: begin
               w_q[i_q] <= w_next;
               // {k, i, j} as one counter keeps j innermost, then i, then k.
               {k_q, i_q, j_q} <= {k_q, i_q, j_q} + 5'd1;
            end
            S_REDUCE: begin
               d_q <= d_next;
            end
            S_DECODE: begin
               for (int unsigned i = 0; i < 4; i++) begin
                  msg_q[3 - i] <= (d_q[i] >= 5'd5) && (d_q[i] <= 5'd12);
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef BABY_KYBER_DECRYPT_NOISE_OUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         noise_out <= '0;
      end else if (state_q == S_DECODE) begin
         noise_out <= d_q;
      end
   end
`endif

endmodule
